// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between pc_sequencer (master) and the memory (slave).
interface pc_sequencer_if;
  logic        imem_req_po;
  logic        imem_valid_pi;
  logic [15:0] imem_data_pi;

  modport master (
    output imem_req_po,
    input  imem_valid_pi,
    input  imem_data_pi
  );

  modport slave (
    input  imem_req_po,
    output imem_valid_pi,
    output imem_data_pi
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control FSM and sole driver of the program counter's control pins.
// Optional fetch watchdog with sticky fault enabled by defining PC_SEQ_TIMEOUT_EN.
module pc_sequencer #(
  parameter logic [3:0] BEQ_OPC = 4'hC,
  parameter logic [3:0] BNE_OPC = 4'hD,
  parameter logic [3:0] JMP_OPC = 4'hE,
  parameter logic [3:0] HLT_OPC = 4'hF
`ifdef PC_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                  clk_pi,
  input  logic                  reset_pi,
  input  logic                  run_pi,
  pc_sequencer_if.master        imem,
  input  logic                  zero_flag_pi,
  input  logic                  exec_done_pi,
  output logic [15:0]           instr_po,
  output logic                  instr_valid_po,
  output logic                  pc_clk_en_po,
  output logic                  pc_reset_po,
  output logic                  branch_taken_po,
  output logic [5:0]            branch_immediate_po,
  output logic                  jump_taken_po,
  output logic [11:0]           jump_immediate_po,
  output logic                  halted_po,
  output logic                  fault_po
);

  typedef enum logic [2:0] {
    CLR,
    FETCH,
    DECODE,
    EXEC,
    UPDATE,
    HALT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        branch_q, branch_d;
  logic        jump_q, jump_d;
  logic        imem_req;
  logic        timeout_hit;
  logic [3:0]  opcode;

  assign opcode           = instr_q[15:12];
  assign instr_po         = instr_q;
  assign imem.imem_req_po = imem_req;

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  // The counter restarts on every entry to FETCH because it is held at zero elsewhere.
  always_comb begin
    cnt_d       = '0;
    timeout_hit = 1'b0;
    if (state_q == FETCH) begin
      cnt_d       = cnt_q + CNT_W'(1);
      timeout_hit = !imem.imem_valid_pi && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end
    fault_d = fault_q | timeout_hit;
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault_po = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign fault_po    = 1'b0;
`endif

  always_comb begin
    state_d             = state_q;
    instr_d             = instr_q;
    branch_d            = branch_q;
    jump_d              = jump_q;
    imem_req            = 1'b0;
    instr_valid_po      = 1'b0;
    pc_clk_en_po        = 1'b0;
    pc_reset_po         = 1'b0;
    branch_taken_po     = 1'b0;
    branch_immediate_po = '0;
    jump_taken_po       = 1'b0;
    jump_immediate_po   = '0;
    halted_po           = 1'b0;

    case (state_q)
      CLR: begin
        pc_reset_po  = 1'b1;
        pc_clk_en_po = 1'b1;
        state_d      = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem.imem_valid_pi) begin
          instr_d = imem.imem_data_pi;
          state_d = DECODE;
        end else if (timeout_hit) begin
          state_d = HALT;
        end
      end
      // Decisions are registered so UPDATE never depends on a late zero flag.
      DECODE: begin
        branch_d = 1'b0;
        jump_d   = 1'b0;
        if (opcode == HLT_OPC) begin
          state_d = HALT;
        end else if (opcode == BEQ_OPC) begin
          branch_d = zero_flag_pi;
          state_d  = UPDATE;
        end else if (opcode == BNE_OPC) begin
          branch_d = !zero_flag_pi;
          state_d  = UPDATE;
        end else if (opcode == JMP_OPC) begin
          jump_d  = 1'b1;
          state_d = UPDATE;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        instr_valid_po = 1'b1;
        if (exec_done_pi) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        pc_clk_en_po        = 1'b1;
        branch_taken_po     = branch_q;
        jump_taken_po       = jump_q;
        branch_immediate_po = instr_q[5:0];
        jump_immediate_po   = instr_q[11:0];
        branch_d            = 1'b0;
        jump_d              = 1'b0;
        state_d             = FETCH;
      end
      HALT: begin
        halted_po = 1'b1;
        if (run_pi) begin
          state_d = UPDATE;
        end
      end
      default: begin
        state_d = CLR;
      end
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q  <= CLR;
      instr_q  <= '0;
      branch_q <= 1'b0;
      jump_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      branch_q <= branch_d;
      jump_q   <= jump_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; PC update expectations go through a scoreboard queue.
module tb_pc_sequencer;

  typedef struct packed {
    logic        br;
    logic        jp;
    logic [5:0]  bimm;
    logic [11:0] jimm;
  } upd_t;

  logic        clk_pi;
  logic        reset_pi;
  logic        run_pi;
  logic        zero_flag_pi;
  logic        exec_done_pi;
  logic [15:0] instr_po;
  logic        instr_valid_po;
  logic        pc_clk_en_po;
  logic        pc_reset_po;
  logic        branch_taken_po;
  logic [5:0]  branch_immediate_po;
  logic        jump_taken_po;
  logic [11:0] jump_immediate_po;
  logic        halted_po;
  logic        fault_po;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk_pi              (clk_pi),
    .reset_pi            (reset_pi),
    .run_pi              (run_pi),
    .imem                (bus),
    .zero_flag_pi        (zero_flag_pi),
    .exec_done_pi        (exec_done_pi),
    .instr_po            (instr_po),
    .instr_valid_po      (instr_valid_po),
    .pc_clk_en_po        (pc_clk_en_po),
    .pc_reset_po         (pc_reset_po),
    .branch_taken_po     (branch_taken_po),
    .branch_immediate_po (branch_immediate_po),
    .jump_taken_po       (jump_taken_po),
    .jump_immediate_po   (jump_immediate_po),
    .halted_po           (halted_po),
    .fault_po            (fault_po)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  upd_t        exp_q[$];
  logic        mon_en   = 1'b0;
  logic [15:0] last_instr;

  initial clk_pi = 1'b0;
  always #5 clk_pi = ~clk_pi;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_pi);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && bus.imem_req_po !== 1'b1; i++) tick();
    checkOutput("req_seen", 32'(bus.imem_req_po), 1);
  endtask

  function automatic upd_t model_update(input logic [15:0] instr, input logic zero);
    upd_t e;
    e.br   = (instr[15:12] == 4'hC && zero) || (instr[15:12] == 4'hD && !zero);
    e.jp   = (instr[15:12] == 4'hE);
    e.bimm = instr[5:0];
    e.jimm = instr[11:0];
    return e;
  endfunction

  // Every PC clock outside CLR must match the oldest scoreboard entry; otherwise the decision outputs stay quiet.
  always @(negedge clk_pi) begin
    upd_t e;
    if (mon_en) begin
      if (pc_clk_en_po === 1'b1 && pc_reset_po === 1'b0) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_update", 32'(pc_clk_en_po), 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("upd_branch_taken", 32'(branch_taken_po), 32'(e.br));
          checkOutput("upd_jump_taken", 32'(jump_taken_po), 32'(e.jp));
          checkOutput("upd_branch_imm", 32'(branch_immediate_po), 32'(e.bimm));
          checkOutput("upd_jump_imm", 32'(jump_immediate_po), 32'(e.jimm));
        end
      end else begin
        checkOutput("idle_decision_outputs",
                    {12'h0, branch_taken_po, jump_taken_po, branch_immediate_po, jump_immediate_po}, 0);
      end
    end
  end

  // Fetches one instruction and walks it through DECODE and, if needed, EXEC; returns in UPDATE or HALT.
  task automatic applyStimulus(input logic [15:0] instr, input logic zero,
                               input int mem_delay, input int exec_delay);
    logic [3:0] op;
    op = instr[15:12];
    wait_req(40);
    for (int i = 0; i < mem_delay; i++) begin
      checkOutput("req_held", 32'(bus.imem_req_po), 1);
      tick();
    end
    bus.imem_valid_pi = 1'b1;
    bus.imem_data_pi  = instr;
    zero_flag_pi      = ~zero;
    last_instr        = instr;
    if (op != 4'hF) exp_q.push_back(model_update(instr, zero));
    tick();
    bus.imem_valid_pi = 1'b0;
    bus.imem_data_pi  = ~instr;
    zero_flag_pi      = zero;
    checkOutput("decode_instr", 32'(instr_po), 32'(instr));
    checkOutput("decode_instr_valid", 32'(instr_valid_po), 0);
    tick();
    zero_flag_pi = ~zero;
    if (op == 4'hF) begin
      checkOutput("halt_entered", 32'(halted_po), 1);
    end else if (op >= 4'hC) begin
      checkOutput("ctrl_update_pc_en", 32'(pc_clk_en_po), 1);
      checkOutput("ctrl_no_instr_valid", 32'(instr_valid_po), 0);
    end else begin
      for (int i = 0; i < exec_delay; i++) begin
        checkOutput("exec_instr_valid_wait", 32'(instr_valid_po), 1);
        tick();
      end
      checkOutput("exec_instr_valid", 32'(instr_valid_po), 1);
      checkOutput("exec_instr", 32'(instr_po), 32'(instr));
      exec_done_pi      = 1'b1;
      bus.imem_valid_pi = 1'b1;
      run_pi            = 1'b1;
      tick();
      exec_done_pi      = 1'b0;
      bus.imem_valid_pi = 1'b0;
      run_pi            = 1'b0;
      checkOutput("update_instr_kept", 32'(instr_po), 32'(instr));
      checkOutput("update_instr_valid", 32'(instr_valid_po), 0);
      checkOutput("update_pc_en", 32'(pc_clk_en_po), 1);
    end
  endtask

  initial begin
    reset_pi          = 1'b1;
    run_pi            = 1'b0;
    zero_flag_pi      = 1'b0;
    exec_done_pi      = 1'b0;
    bus.imem_valid_pi = 1'b0;
    bus.imem_data_pi  = 16'h0;
    last_instr        = 16'h0;
    $display("[TB] starting pc_sequencer bench");

    tick();
    checkOutput("rst_pc_reset", 32'(pc_reset_po), 1);
    checkOutput("rst_pc_clk_en", 32'(pc_clk_en_po), 1);
    checkOutput("rst_instr", 32'(instr_po), 0);
    checkOutput("rst_quiet_outputs",
                {26'h0, bus.imem_req_po, instr_valid_po, branch_taken_po, jump_taken_po, halted_po, fault_po}, 0);
    mon_en   = 1'b1;
    reset_pi = 1'b0;
    tick();
    checkOutput("clr_one_cycle", 32'(pc_reset_po), 0);
    checkOutput("fetch_no_pc_en", 32'(pc_clk_en_po), 0);

    applyStimulus(16'h1234, 1'b0, 0, 0);
    applyStimulus(16'hC03E, 1'b1, 0, 0);
    applyStimulus(16'hC03E, 1'b0, 0, 0);
    applyStimulus(16'hD005, 1'b0, 1, 0);
    applyStimulus(16'hD005, 1'b1, 0, 0);
    applyStimulus(16'hE800, 1'b1, 0, 0);
    tick();
    checkOutput("jump_single_cycle", 32'(pc_clk_en_po), 0);
    applyStimulus(16'h5A5A, 1'b0, 2, 3);

    applyStimulus(16'hF000, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("halt_held", 32'(halted_po), 1);
      checkOutput("halt_pc_frozen", 32'(pc_clk_en_po), 0);
      tick();
    end
    run_pi = 1'b1;
    exp_q.push_back(model_update(16'hF000, 1'b0));
    tick();
    run_pi = 1'b0;
    checkOutput("run_update_pc_en", 32'(pc_clk_en_po), 1);
    checkOutput("run_left_halt", 32'(halted_po), 0);
    tick();
    checkOutput("run_then_fetch", 32'(bus.imem_req_po), 1);

    wait_req(40);
    for (int i = 0; i < 5; i++) begin
      checkOutput("slow_mem_req_held", 32'(bus.imem_req_po), 1);
      tick();
    end
    bus.imem_valid_pi = 1'b1;
    bus.imem_data_pi  = 16'h2222;
    tick();
    bus.imem_valid_pi = 1'b0;
    tick();
    checkOutput("slow_exec_valid", 32'(instr_valid_po), 1);
    reset_pi = 1'b1;
    tick();
    checkOutput("exec_rst_pc_reset", 32'(pc_reset_po), 1);
    checkOutput("exec_rst_pc_clk_en", 32'(pc_clk_en_po), 1);
    checkOutput("exec_rst_instr_valid", 32'(instr_valid_po), 0);
    checkOutput("exec_rst_instr", 32'(instr_po), 0);
    reset_pi   = 1'b0;
    last_instr = 16'h0;
    tick();
    checkOutput("exec_rst_fetch_req", 32'(bus.imem_req_po), 1);
    checkOutput("exec_rst_clr_done", 32'(pc_reset_po), 0);

`ifdef PC_SEQ_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      checkOutput("timeout_fetch_wait", {30'h0, bus.imem_req_po, halted_po}, 32'h2);
      tick();
    end
    checkOutput("timeout_halted", 32'(halted_po), 1);
    checkOutput("timeout_fault", 32'(fault_po), 1);
    checkOutput("timeout_req_dropped", 32'(bus.imem_req_po), 0);
    run_pi = 1'b1;
    exp_q.push_back(model_update(last_instr, 1'b0));
    tick();
    run_pi = 1'b0;
    checkOutput("timeout_run_update", 32'(pc_clk_en_po), 1);
    checkOutput("fault_sticky_update", 32'(fault_po), 1);
    tick();
    checkOutput("fault_sticky_fetch", 32'(fault_po), 1);
    applyStimulus(16'h3333, 1'b0, 0, 0);
    checkOutput("fault_sticky_resume", 32'(fault_po), 1);
`else
    applyStimulus(16'h3333, 1'b0, 0, 0);
    checkOutput("fault_tied_low", 32'(fault_po), 0);
`endif

    tick();
    tick();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control FSM that drives the 16-bit program counter's enable, reset, branch and jump inputs.
- Fetches each instruction from instruction memory over a req/valid handshake and decodes the control-flow opcodes.
- Hands non-control instructions to the datapath and waits for completion, then advances the PC.
- Sits between instruction memory, the program counter and the execute datapath; it is the only driver of the PC's control pins.

Parameters:
- BEQ_OPC, 4'hC, opcode: branch if zero flag set.
- BNE_OPC, 4'hD, opcode: branch if zero flag clear.
- JMP_OPC, 4'hE, opcode: unconditional jump.
- HLT_OPC, 4'hF, opcode: halt.
- TIMEOUT_CYCLES, 16, fetch watchdog limit. Used only with PC_SEQ_TIMEOUT_EN.

Ports:
- clk_pi  in  1  clock; all state changes on its rising edge.
- reset_pi  in  1  synchronous, active-high reset.
- run_pi  in  1  single-cycle pulse; resumes execution from HALT.
- imem_req_po  out  1  fetch request to instruction memory.
- imem_valid_pi  in  1  instruction data valid.
- imem_data_pi  in  16  instruction word.
- zero_flag_pi  in  1  ALU zero flag.
- exec_done_pi  in  1  datapath has finished the issued instruction.
- instr_po  out  16  latched instruction.
- instr_valid_po  out  1  instr_po is to be executed.
- pc_clk_en_po  out  1  program counter clock enable.
- pc_reset_po  out  1  program counter synchronous clear.
- branch_taken_po  out  1  branch taken.
- branch_immediate_po  out  6  branch offset, instr[5:0].
- jump_taken_po  out  1  jump taken.
- jump_immediate_po  out  12  jump offset, instr[11:0].
- halted_po  out  1  sequencer is in HALT.
- fault_po  out  1  fetch timeout occurred. Tied 0 without PC_SEQ_TIMEOUT_EN.

Behaviour:
- States: CLR, FETCH, DECODE, EXEC, UPDATE, HALT. Opcode is instr[15:12].
- Reset:
  - reset_pi=1 forces CLR on the next edge, from any state and mid-handshake.
  - instr_po=0 and every *_po output is 0, except as driven by CLR below.
- CLR:
  - pc_reset_po=1 and pc_clk_en_po=1 for exactly one cycle.
  - Then FETCH.
- FETCH:
  - imem_req_po=1 and held until the cycle where imem_valid_pi=1.
  - In that cycle imem_data_pi is latched into instr_po, then DECODE.
  - imem_valid_pi is ignored in every other state.
- DECODE (one cycle):
  - zero_flag_pi is sampled here only.
  - HLT_OPC -> HALT. PC is not updated.
  - BEQ_OPC with zero=1, or BNE_OPC with zero=0: register branch_taken=1 -> UPDATE.
  - BEQ/BNE not taken -> UPDATE with both taken flags 0, i.e. a plain PC+2.
  - JMP_OPC: register jump_taken=1 -> UPDATE.
  - Any other opcode -> EXEC.
- EXEC:
  - instr_valid_po=1 until and including the cycle exec_done_pi=1, then UPDATE.
  - exec_done_pi is ignored in every other state.
- UPDATE (exactly one cycle):
  - pc_clk_en_po=1; branch_taken_po/jump_taken_po show the registered decisions.
  - branch_immediate_po = instr_po[5:0]; jump_immediate_po = instr_po[11:0], unextended.
  - Never both taken flags at once. Then FETCH.
  - The taken flags and immediates are 0 outside UPDATE.
- HALT:
  - halted_po=1; the PC is frozen (pc_clk_en_po=0).
  - run_pi=1 -> UPDATE with no taken flag, so the PC advances past the halt instruction.
  - run_pi is ignored outside HALT.
- Latency for a non-control instruction with zero-wait memory and exec_done in its first EXEC cycle: FETCH -> DECODE -> EXEC -> UPDATE, 4 cycles. Branch/jump: 3 cycles.
- Simultaneous reset_pi with any event: reset wins.

Optional Feature:
- Macro: PC_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs while in FETCH and clears on entry to FETCH.
  - If imem_valid_pi is still 0 after TIMEOUT_CYCLES cycles in FETCH, go to HALT and set fault_po=1.
  - fault_po is sticky until reset_pi. run_pi does not clear it, but does resume execution.
- Undefined: no counter; FETCH waits indefinitely; fault_po is constant 0.

Test Plan:
- Reset, then memory answers instr 16'h1234 in the same cycle, exec_done on the 1st EXEC cycle:
  - pc_reset_po and pc_clk_en_po pulse for 1 cycle.
  - instr_po=16'h1234, instr_valid_po for 1 cycle.
  - One pc_clk_en_po pulse with both taken flags 0.
- BEQ 16'hC03E (offset -2):
  - With zero_flag=1: UPDATE shows branch_taken_po=1, branch_immediate_po=6'h3E, jump_taken_po=0.
  - With zero_flag=0: both taken flags 0, pc_clk_en_po=1.
- JMP 16'hE800: jump_taken_po=1, jump_immediate_po=12'h800 for exactly one pc_clk_en cycle.
- HLT 16'hF000:
  - halted_po=1 and no pc_clk_en for 10 cycles.
  - run_pi pulse: one pc_clk_en with no taken flags, then imem_req_po=1.
- imem_valid delayed 5 cycles, then reset_pi asserted in EXEC:
  - imem_req_po held for all 5 cycles.
  - After reset: the CLR pulse, instr_valid_po=0, then FETCH.
- With PC_SEQ_TIMEOUT_EN, no imem_valid: after 16 FETCH cycles halted_po=1 and fault_po=1; fault_po stays 1 after run_pi.
